stage_if: RTL and testbench
===========================

# stage_if

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core. Holds the PC, issues one-outstanding word fetches to instruction memory over a req/ack handshake of variable latency, and presents fetched instructions to the decode stage. Consumes decode's branch redirect (`br`/`br_addr`) with MIPS delay-slot semantics, and honours the pipeline stall from the controller through a one-entry skid buffer.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request; held until `imem_ack`.
- `imem_addr`  out  32  fetch address; stable while `imem_req` is high.
- `imem_ack`  in  1  one-cycle completion; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched word.
- `stall`  in  1  decode cannot accept a new instruction this cycle.
- `br`  in  1  decode resolves a taken branch/jump this cycle.
- `br_addr`  in  32  branch target.
- `id_pc`  out  32  PC of instruction in decode.
- `id_inst`  out  32  instruction in decode; 0 (NOP) when invalid.
- `id_valid`  out  1  `id_inst` is a real instruction.
- `id_in_delay_slot`  out  1  `id_inst` is a branch delay slot.
- `stallreq`  out  1  high while in FETCH without ack (fetch bubble pending).

## Operation
- States: FETCH (request outstanding for `pc`), HOLD (skid full, no request).
- `imem_req` = (state==FETCH); `imem_addr` = `pc`.
- Branch capture: `br_take` = `br && id_valid && !stall`; sampled only then.
- FETCH, ack, `!stall`: `id_inst`<=`imem_rdata`, `id_pc`<=`pc`, `id_valid`<=1, `pc`<=next; stay FETCH.
- FETCH, ack, `stall`: skid<={`pc`,`imem_rdata`}, `pc`<=next, go HOLD; outputs held.
- FETCH, no ack, `!stall`: bubble: `id_valid`<=0, `id_inst`<=0; `id_pc` held.
- HOLD, `!stall`: skid moves to output, `id_valid`<=1, go FETCH.
- Any state, `stall`: `id_*` outputs held.
- next = `br_take` ? `br_addr` : `pend_v` ? `pend_addr` : `pc`+4.
- In FETCH, `br_take` without ack sets `pend_v`/`pend_addr`; request in flight is the delay slot and is never aborted. `pend_v` clears when consumed by an ack.
- In HOLD, `br_take` overwrites `pc` with `br_addr` directly (skid already holds the delay slot).
- Delay-slot tracking: `ds_flag` set by `br_take`; the next instruction delivered (`id_valid`<=1) gets `id_in_delay_slot`=1 and clears `ds_flag`. `br_take` coincident with a delivery marks that delivered word. Bubbles carry 0.
- PC arithmetic is modulo 2^32; `pc`+4 wraps from 32'hFFFF_FFFC to 0. No alignment check.

## Timing
- Reset (any cycle, including mid-request): `pc`=`RESET_PC`, state=FETCH, `id_valid`=0, `id_inst`=0, `id_pc`=0, `id_in_delay_slot`=0, `pend_v`=0, `ds_flag`=0, skid empty. `imem_req`=1 in the first cycle after reset. A late ack for a pre-reset request is not expected; memory is reset alongside.
- Ack in cycle N: instruction visible at decode in cycle N+1 when `!stall`.
- Zero-wait memory (ack same cycle as req): one instruction per cycle, no bubbles.
- Taken branch: exactly one delay-slot instruction, then target; no wrong-path instruction ever reaches decode.
- `stallreq` is combinational: state==FETCH && !`imem_ack`.

## Configuration
- `IF_PERF_CNT_EN`: defined adds outputs `perf_fetch_cnt` (32, increments per delivered instruction) and `perf_wait_cnt` (32, increments per cycle `stallreq`=1); both wrap, reset to 0. Undefined: ports and counters absent; all other behaviour identical.

## Structure
- `consts.v`: `ZERO_WORD`, `INST_ADDR_BUS`/`INST_BUS` widths, default `RESET_PC` value. FSM encoding is a local parameter.
- Sub-module `if_skid_buf`: one-entry {pc, inst} buffer with load/unload/full.

## Test plan
- Reset, ack every cycle from 0xBFC00000 -> `id_pc` 0xBFC00000, …04, …08 on consecutive cycles, `id_valid`=1.
- Ack latency 3 -> `stallreq` high 2 cycles/fetch; `id_valid`=0, `id_inst`=0 during bubbles.
- `br`=1, `br_addr`=0x1000 with branch at 0x100, delay slot ack 2 cycles later -> decode sees 0x104 with `id_in_delay_slot`=1, then 0x1000; 0x108 never appears.
- `stall` asserted as ack of 0x200 arrives, held 3 cycles -> `id_*` frozen, HOLD, `imem_req`=0; release -> 0x200 delivered, fetch of 0x204 next.
- In HOLD with skid=0x304, `br_take` to 0x2000 -> 0x304 delivered as delay slot, next request addr 0x2000.
- `rst` pulsed while `imem_req` high at 0x500 -> next cycle `imem_addr`=`RESET_PC`, all outputs at reset values.

Source files
------------

// File: rtl/stage_if_pkg.sv
// rtl/stage_if_pkg.sv - shared widths, constants and FSM encoding for the fetch stage
package stage_if_pkg;

    localparam int          INST_ADDR_BUS    = 32;
    localparam int          INST_BUS         = 32;
    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // FETCH: a request for pc is outstanding. HOLD: skid full, no request.
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } if_state_t;

endpackage

// File: rtl/if_skid_buf.sv
// rtl/if_skid_buf.sv - one-entry {pc, inst} skid buffer for the fetch stage
//
// Ports: clk, rst (sync, active-high); load captures {load_pc, load_inst} and
// sets full; unload clears full. pc/inst present the held entry.
module if_skid_buf
    import stage_if_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     unload,
    input  logic [INST_ADDR_BUS-1:0] load_pc,
    input  logic [INST_BUS-1:0]      load_inst,
    output logic                     full,
    output logic [INST_ADDR_BUS-1:0] pc,
    output logic [INST_BUS-1:0]      inst
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            pc   <= ZERO_WORD;
            inst <= ZERO_WORD;
        end else if (load) begin
            full <= 1'b1;
            pc   <= load_pc;
            inst <= load_inst;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/stage_if.sv
// rtl/stage_if.sv - MIPS instruction fetch stage with IF/ID register and skid buffer
//
// Ports: clk, rst (sync, active-high); imem_req/imem_addr/imem_ack/imem_rdata
// one-outstanding fetch handshake; stall from the controller; br/br_addr
// redirect from decode; id_pc/id_inst/id_valid/id_in_delay_slot to decode;
// stallreq flags a pending fetch bubble.
// Optional macro IF_PERF_CNT_EN adds perf_fetch_cnt and perf_wait_cnt.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [INST_ADDR_BUS-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [INST_ADDR_BUS-1:0] imem_addr,
    input  logic                     imem_ack,
    input  logic [INST_BUS-1:0]      imem_rdata,
    input  logic                     stall,
    input  logic                     br,
    input  logic [INST_ADDR_BUS-1:0] br_addr,
    output logic [INST_ADDR_BUS-1:0] id_pc,
    output logic [INST_BUS-1:0]      id_inst,
    output logic                     id_valid,
    output logic                     id_in_delay_slot,
    output logic                     stallreq
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]              perf_fetch_cnt,
    output logic [31:0]              perf_wait_cnt
`endif
);

    if_state_t                  state;
    logic [INST_ADDR_BUS-1:0]   pc;
    logic                       pend_v;
    logic [INST_ADDR_BUS-1:0]   pend_addr;
    logic                       ds_flag;

    logic                       skid_full;
    logic [INST_ADDR_BUS-1:0]   skid_pc;
    logic [INST_BUS-1:0]        skid_inst;

    logic                       br_take;
    logic [INST_ADDR_BUS-1:0]   next_pc;
    logic                       fetch_ack;
    logic                       skid_load;
    logic                       skid_unload;
    logic                       deliver;

    // A redirect only counts when the branch really sits in decode and moves on.
    assign br_take     = br && id_valid && !stall;
    assign next_pc     = br_take ? br_addr : (pend_v ? pend_addr : pc + 32'd4);
    assign fetch_ack   = (state == ST_FETCH) && imem_ack;
    assign skid_load   = fetch_ack && stall;
    assign skid_unload = (state == ST_HOLD) && !stall && skid_full;
    assign deliver     = (fetch_ack && !stall) || skid_unload;

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign stallreq  = (state == ST_FETCH) && !imem_ack;

    if_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .unload    (skid_unload),
        .load_pc   (pc),
        .load_inst (imem_rdata),
        .full      (skid_full),
        .pc        (skid_pc),
        .inst      (skid_inst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_FETCH;
            pc               <= RESET_PC;
            pend_v           <= 1'b0;
            pend_addr        <= ZERO_WORD;
            ds_flag          <= 1'b0;
            id_pc            <= ZERO_WORD;
            id_inst          <= ZERO_WORD;
            id_valid         <= 1'b0;
            id_in_delay_slot <= 1'b0;
        end else begin
            if (state == ST_FETCH) begin
                if (imem_ack) begin
                    pc     <= next_pc;
                    pend_v <= 1'b0;
                    if (stall) begin
                        state <= ST_HOLD;
                    end
                end else if (br_take) begin
                    // The word in flight is the delay slot; remember the target.
                    pend_v    <= 1'b1;
                    pend_addr <= br_addr;
                end
            end else if (skid_unload) begin
                state <= ST_FETCH;
                // pc already points past the skid word, which is the delay slot.
                if (br_take) begin
                    pc <= br_addr;
                end
            end

            if (deliver) begin
                id_valid         <= 1'b1;
                id_pc            <= skid_unload ? skid_pc : pc;
                id_inst          <= skid_unload ? skid_inst : imem_rdata;
                id_in_delay_slot <= ds_flag || br_take;
                ds_flag          <= 1'b0;
            end else if (!stall) begin
                id_valid         <= 1'b0;
                id_inst          <= ZERO_WORD;
                id_in_delay_slot <= 1'b0;
                if (br_take) begin
                    ds_flag <= 1'b1;
                end
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_wait_cnt  <= 32'd0;
        end else begin
            if (deliver) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stallreq) begin
                perf_wait_cnt <= perf_wait_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stage_if.sv
// tb/tb_stage_if.sv - self-checking bench for stage_if
module tb_stage_if;

    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        br;
    logic [31:0] br_addr;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_in_delay_slot;
    logic        stallreq;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wait_cnt;
`endif

    always #5 clk = ~clk;

    stage_if #(.RESET_PC(RPC)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .stall            (stall),
        .br               (br),
        .br_addr          (br_addr),
        .id_pc            (id_pc),
        .id_inst          (id_inst),
        .id_valid         (id_valid),
        .id_in_delay_slot (id_in_delay_slot),
        .stallreq         (stallreq)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_wait_cnt    (perf_wait_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // memory model: ack after wait_cyc cycles of an outstanding request
    int  cnt        = 0;
    int  wait_cyc   = 0;
    int  fixed_wait = 0;
    bit  rand_lat   = 0;
    bit  last_stallreq;

    // program-order model: next pc to reach decode, delay-slot marking, target
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    bit          exp_ds;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic new_wait();
        wait_cyc = rand_lat ? int'($urandom_range(0, 3)) : fixed_wait;
    endtask

    task automatic model_reset();
        exp_pc = RPC;
        exp_ds = 0;
        tgt    = 32'h0;
        cnt    = 0;
        new_wait();
    endtask

    task automatic chk_reset_state();
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_inst", id_inst, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_ds", {31'b0, id_in_delay_slot}, 32'd0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd1);
        chk("rst_imem_addr", imem_addr, RPC);
    endtask

    // one clock: drive memory response, check, clock, check against the model
    task automatic cycle();
        logic        p_req, p_ack, p_stall, p_take, p_rst, p_valid, p_ds;
        logic [31:0] p_addr, p_pc, p_inst, p_br_addr;
        p_req     = imem_req;
        p_addr    = imem_addr;
        p_ack     = p_req && (cnt >= wait_cyc);
        imem_ack  = p_ack;
        imem_rdata = p_ack ? mem_word(p_addr) : 32'hDEAD_BEEF;
        p_stall   = stall;
        p_rst     = rst;
        p_valid   = id_valid;
        p_ds      = id_in_delay_slot;
        p_pc      = id_pc;
        p_inst    = id_inst;
        p_br_addr = br_addr;
        p_take    = br && id_valid && !stall && !rst;
        #1;
        last_stallreq = stallreq;
        chk("stallreq", {31'b0, stallreq}, {31'b0, p_req && !p_ack});
        @(posedge clk);
        #1;
        if (p_rst) begin
            model_reset();
        end else begin
            if (p_ack) begin
                cnt = 0;
                new_wait();
            end else if (p_req) begin
                cnt++;
            end
            if (p_take) begin
                exp_ds = 1;
                tgt    = p_br_addr;
            end
            if (p_stall) begin
                chk("hold_valid", {31'b0, id_valid}, {31'b0, p_valid});
                chk("hold_pc", id_pc, p_pc);
                chk("hold_inst", id_inst, p_inst);
                chk("hold_ds", {31'b0, id_in_delay_slot}, {31'b0, p_ds});
            end else if (id_valid) begin
                chk("deliv_pc", id_pc, exp_pc);
                chk("deliv_inst", id_inst, mem_word(exp_pc));
                chk("deliv_ds", {31'b0, id_in_delay_slot}, {31'b0, exp_ds});
                if (exp_ds) begin
                    exp_pc = tgt;
                    exp_ds = 0;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
            end else begin
                chk("bubble_inst", id_inst, 32'h0);
                chk("bubble_ds", {31'b0, id_in_delay_slot}, 32'd0);
                chk("bubble_pc", id_pc, p_pc);
            end
            if (p_req && !p_ack) begin
                chk("req_held", {31'b0, imem_req}, 32'd1);
                chk("addr_stable", imem_addr, p_addr);
            end
        end
    endtask

    task automatic wait_deliv(input logic [31:0] want, input string tag);
        bit seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cycle();
            if (!stall && id_valid && id_pc == want) seen = 1;
        end
        chk(tag, {31'b0, seen}, 32'd1);
    endtask

    // take a branch from whatever non-delay-slot instruction is next in decode
    task automatic branch_to(input logic [31:0] a);
        bit ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (id_valid && !id_in_delay_slot) ok = 1;
            else cycle();
        end
        chk("branch_ready", {31'b0, ok}, 32'd1);
        br      = 1;
        br_addr = a;
        cycle();
        br = 0;
    endtask

    initial begin
        int  sr;
        int  dv;
        bit  found;
        rst        = 1;
        stall      = 0;
        br         = 0;
        br_addr    = 32'h0;
        imem_ack   = 0;
        imem_rdata = 32'h0;
        @(posedge clk);
        #1;
        cycle();
        rst = 0;
        chk_reset_state();

        // zero-wait memory: one instruction per cycle
        cycle();
        chk("seq0", id_pc, 32'hBFC0_0000);
        cycle();
        chk("seq1", id_pc, 32'hBFC0_0004);
        cycle();
        chk("seq2", id_pc, 32'hBFC0_0008);
        chk("seq_valid", {31'b0, id_valid}, 32'd1);

        // latency 3: two bubble cycles per fetch
        fixed_wait = 2;
        wait_cyc   = 2;
        sr = 0;
        dv = 0;
        for (int k = 0; k < 9; k++) begin
            cycle();
            sr += int'(last_stallreq);
            dv += int'(id_valid);
        end
        chk("lat3_stallreq", sr, 32'd6);
        chk("lat3_deliv", dv, 32'd3);

        // branch at 0x100 to 0x1000: delay slot 0x104, then target
        branch_to(32'h0000_00FC);
        wait_deliv(32'h0000_0100, "reach_100");
        br      = 1;
        br_addr = 32'h0000_1000;
        cycle();
        br = 0;
        wait_deliv(32'h0000_0104, "ds_104");
        chk("ds_104_flag", {31'b0, id_in_delay_slot}, 32'd1);
        wait_deliv(32'h0000_1000, "tgt_1000");
        chk("tgt_1000_flag", {31'b0, id_in_delay_slot}, 32'd0);

        // stall as ack of 0x200 arrives, held 3 cycles
        branch_to(32'h0000_0200);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (imem_req && imem_addr == 32'h0000_0200 && cnt >= wait_cyc) found = 1;
            else cycle();
        end
        chk("ack_200_seen", {31'b0, found}, 32'd1);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("hold_no_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 0;
        cycle();
        chk("rel_pc", id_pc, 32'h0000_0200);
        chk("rel_valid", {31'b0, id_valid}, 32'd1);
        chk("rel_req", {31'b0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0000_0204);

        // branch taken while the skid holds the delay slot 0x304
        fixed_wait = 0;
        wait_cyc   = 0;
        branch_to(32'h0000_0300);
        wait_deliv(32'h0000_0300, "reach_300");
        stall = 1;
        cycle();
        chk("skid_hold_req", {31'b0, imem_req}, 32'd0);
        stall   = 0;
        br      = 1;
        br_addr = 32'h0000_2000;
        cycle();
        br = 0;
        chk("skid_ds_pc", id_pc, 32'h0000_0304);
        chk("skid_ds_flag", {31'b0, id_in_delay_slot}, 32'd1);
        chk("skid_next_addr", imem_addr, 32'h0000_2000);
        chk("skid_next_req", {31'b0, imem_req}, 32'd1);
        cycle();
        chk("skid_tgt_pc", id_pc, 32'h0000_2000);
        chk("skid_tgt_ds", {31'b0, id_in_delay_slot}, 32'd0);

        // reset in the middle of a request at 0x500
        fixed_wait = 3;
        wait_cyc   = 3;
        branch_to(32'h0000_0500);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (imem_req && imem_addr == 32'h0000_0500) found = 1;
            else cycle();
        end
        chk("req_500_seen", {31'b0, found}, 32'd1);
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        chk_reset_state();

        // pc wraps from 0xFFFFFFFC to 0
        fixed_wait = 0;
        wait_cyc   = 0;
        cycle();
        branch_to(32'hFFFF_FFF8);
        wait_deliv(32'hFFFF_FFF8, "wrap_f8");
        wait_deliv(32'hFFFF_FFFC, "wrap_fc");
        wait_deliv(32'h0000_0000, "wrap_0");

        // randomized traffic: latency, stall, branches, ignored branch pulses
        rand_lat = 1;
        for (int k = 0; k < 1500; k++) begin
            stall = ($urandom_range(0, 3) == 0);
            if (id_valid && !id_in_delay_slot && $urandom_range(0, 6) == 0) begin
                br      = 1;
                br_addr = $urandom() & 32'hFFFF_FFFC;
            end else begin
                br      = !id_valid && ($urandom_range(0, 4) == 0);
                br_addr = $urandom();
            end
            cycle();
        end
        stall = 0;
        br    = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
